// File: rtl/array_req_pkg.sv
// array_req_pkg -- shared types for the array request controller.
//
// Contents:
//   state_e : controller state. IDLE serves client requests. FLUSH sweeps
//             zeros through every array entry, one entry per cycle.
package array_req_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/array_req_ctrl.sv
// array_req_ctrl -- request/response front end for a small storage array
// whose reads return one cycle after they are issued (registered read).
//
// Build option:
//   ARRAY_REQ_CTRL_FLUSH_EN : when defined, adds the FLUSH sweep that writes
//                             zero to every entry. When undefined, flush_req
//                             is ignored and flush_busy is tied low.
//
// Parameters:
//   s_index : index width (num_sets = 2**s_index)
//   width   : data width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    client request handshake
//   req_we                   1 = write, 0 = read
//   req_index, req_wdata     target entry and write data
//   resp_valid / resp_ready  read response handshake
//   resp_rdata               read data (the array output, passed straight through)
//   flush_req / flush_busy   start a zeroing sweep / sweep in progress
//   arr_read, arr_rindex     array read strobe and index
//   arr_load, arr_windex     array write strobe and index
//   arr_datain, arr_dataout  array write data / registered read data
module array_req_ctrl
  import array_req_pkg::*;
#(
  parameter int s_index = 3,
  parameter int width   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [s_index-1:0] req_index,
  input  logic [width-1:0]   req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [width-1:0]   resp_rdata,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               arr_read,
  output logic               arr_load,
  output logic [s_index-1:0] arr_rindex,
  output logic [s_index-1:0] arr_windex,
  output logic [width-1:0]   arr_datain,
  input  logic [width-1:0]   arr_dataout
);

  logic               r_resp_valid;
  logic               w_resp_free;
  logic               w_accept;
  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_flushing;
  logic [s_index-1:0] w_flush_windex;

  // A new request may proceed when no response is held, or when the held
  // response is being consumed this cycle. This is what allows back-to-back reads.
  assign w_resp_free = !r_resp_valid || resp_ready;

`ifdef ARRAY_REQ_CTRL_FLUSH_EN
  state_e             r_state;
  logic [s_index-1:0] r_cnt;
  logic               w_flush_acc;

  // flush_req takes priority over a request in the same cycle. A flush only
  // starts once no response is held, so the read data is never lost.
  assign req_ready   = !rst && (r_state == IDLE) && !flush_req && w_resp_free;
  assign w_flush_acc = !rst && (r_state == IDLE) && flush_req && !r_resp_valid;
  // Reset in the middle of a sweep blocks that cycle's write. Entries the
  // sweep has not reached yet keep their contents.
  assign w_flushing     = !rst && (r_state == FLUSH);
  assign w_flush_windex = r_cnt;
  assign flush_busy     = (r_state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_flush_acc) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end
        end
        FLUSH: begin
          // The counter wraps naturally to 0 on the last entry, which
          // leaves it ready for the next sweep.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {s_index{1'b1}}) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused_flush;

  assign w_unused_flush = flush_req;
  assign req_ready      = !rst && w_resp_free;
  assign w_flushing     = 1'b0;
  assign w_flush_windex = '0;
  assign flush_busy     = 1'b0;
`endif

  assign w_accept = req_valid && req_ready;
  assign w_rd_acc = w_accept && !req_we;
  assign w_wr_acc = w_accept && req_we;

  // Array strobes are combinational in the accept cycle. Because arr_read
  // stays low while a response is held, arr_dataout keeps the read result
  // until the client consumes it.
  assign arr_read   = w_rd_acc;
  assign arr_rindex = req_index;
  assign arr_load   = w_wr_acc || w_flushing;
  assign arr_windex = w_flushing ? w_flush_windex : req_index;
  assign arr_datain = w_flushing ? '0 : req_wdata;

  // ---- response stage: valid one cycle after read accept ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_resp_valid <= 1'b1;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = arr_dataout;

endmodule

// File: tb/tb_array_req_ctrl.sv
module tb_array_req_ctrl;

  localparam int S = 3;
  localparam int W = 1;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [S-1:0] req_index;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_rdata;
  logic         flush_req;
  logic         flush_busy;
  logic         arr_read;
  logic         arr_load;
  logic [S-1:0] arr_rindex;
  logic [S-1:0] arr_windex;
  logic [W-1:0] arr_datain;
  logic [W-1:0] arr_dataout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  array_req_ctrl #(.s_index(S), .width(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_index(req_index), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .arr_read(arr_read), .arr_load(arr_load),
    .arr_rindex(arr_rindex), .arr_windex(arr_windex),
    .arr_datain(arr_datain), .arr_dataout(arr_dataout)
  );

  // array_2 storage: synchronous write, one-cycle registered read
  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    if (arr_load) mem[arr_windex] <= arr_datain;
    if (arr_read) arr_dataout <= mem[arr_rindex];
  end

  typedef struct packed {
    logic         we;
    logic [S-1:0] idx;
    logic [W-1:0] wdata;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_write(input logic [S-1:0] idx, input logic [W-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_index = idx; req_wdata = d;
    #1;
    chk($sformatf("wr%0d_ready", idx), 32'(req_ready), 32'd1);
    chk($sformatf("wr%0d_load", idx), 32'(arr_load), 32'd1);
    chk($sformatf("wr%0d_windex", idx), 32'(arr_windex), 32'(idx));
    chk($sformatf("wr%0d_datain", idx), 32'(arr_datain), 32'(d));
    chk($sformatf("wr%0d_noread", idx), 32'(arr_read), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    chk($sformatf("wr%0d_noresp", idx), 32'(resp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [S-1:0] idx, input logic [W-1:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_index = idx; resp_ready = 1'b0;
    #1;
    chk($sformatf("rd%0d_ready", idx), 32'(req_ready), 32'd1);
    chk($sformatf("rd%0d_read", idx), 32'(arr_read), 32'd1);
    chk($sformatf("rd%0d_rindex", idx), 32'(arr_rindex), 32'(idx));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk($sformatf("rd%0d_valid", idx), 32'(resp_valid), 32'd1);
    chk($sformatf("rd%0d_data", idx), 32'(resp_rdata), 32'(exp));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk($sformatf("rd%0d_consumed", idx), 32'(resp_valid), 32'd0);
  endtask

  task automatic write_all(input logic [W-1:0] d);
    for (int i = 0; i < N; i++) do_write(S'(i), d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd5, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd7, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 3'd5, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'd5, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_index = '0; req_wdata = '0;
    resp_ready = 1'b0; flush_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_read", 32'(arr_read), 32'd0);
    chk("post_rst_load", 32'(arr_load), 32'd0);

    // Table-driven write/read vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) do_write(vecs[i].idx, vecs[i].wdata);
      else            do_read(vecs[i].idx, vecs[i].exp);
    end

    // Stalled response: idx 2 holds 1, and a blocked read of idx 5 (value 0)
    // must not disturb the array output.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_index = 3'd2; resp_ready = 1'b0;
    #1;
    chk("stall_accept_read", 32'(arr_read), 32'd1);
    @(negedge clk);
    req_index = 3'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("stall%0d_noread", c), 32'(arr_read), 32'd0);
      chk($sformatf("stall%0d_data", c), 32'(resp_rdata), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("stall_release_data", 32'(resp_rdata), 32'd1);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("stall_consumed", 32'(resp_valid), 32'd0);

    // Back-to-back reads: idx 7 = 1, then idx 0 = 0
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_index = 3'd7; resp_ready = 1'b0;
    #1;
    chk("b2b_first_read", 32'(arr_read), 32'd1);
    @(negedge clk);
    req_index = 3'd0; resp_ready = 1'b1;
    #1;
    chk("b2b_first_valid", 32'(resp_valid), 32'd1);
    chk("b2b_first_data", 32'(resp_rdata), 32'd1);
    chk("b2b_ready", 32'(req_ready), 32'd1);
    chk("b2b_second_read", 32'(arr_read), 32'd1);
    chk("b2b_second_rindex", 32'(arr_rindex), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("b2b_second_valid", 32'(resp_valid), 32'd1);
    chk("b2b_second_data", 32'(resp_rdata), 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("b2b_consumed", 32'(resp_valid), 32'd0);

`ifdef ARRAY_REQ_CTRL_FLUSH_EN
    // Full flush sweep
    write_all(1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    chk("flush_req_blocks_ready", 32'(req_ready), 32'd0);
    chk("flush_accept_noload", 32'(arr_load), 32'd0);
    @(negedge clk);
    flush_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      chk($sformatf("flush%0d_busy", k), 32'(flush_busy), 32'd1);
      chk($sformatf("flush%0d_load", k), 32'(arr_load), 32'd1);
      chk($sformatf("flush%0d_windex", k), 32'(arr_windex), 32'(k));
      chk($sformatf("flush%0d_datain", k), 32'(arr_datain), 32'd0);
      chk($sformatf("flush%0d_ready", k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("flush_done_busy", 32'(flush_busy), 32'd0);
    chk("flush_done_ready", 32'(req_ready), 32'd1);
    chk("flush_done_load", 32'(arr_load), 32'd0);
    for (int i = 0; i < N; i++) do_read(S'(i), 1'b0);

    // flush_req beats a same-cycle write, which waits for the sweep
    @(negedge clk);
    flush_req = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_index = 3'd3; req_wdata = 1'b1;
    #1;
    chk("prio_ready_low", 32'(req_ready), 32'd0);
    chk("prio_noload", 32'(arr_load), 32'd0);
    @(negedge clk);
    flush_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      chk($sformatf("prio%0d_busy", k), 32'(flush_busy), 32'd1);
      chk($sformatf("prio%0d_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("prio%0d_windex", k), 32'(arr_windex), 32'(k));
      @(negedge clk);
    end
    #1;
    chk("prio_after_ready", 32'(req_ready), 32'd1);
    chk("prio_after_load", 32'(arr_load), 32'd1);
    chk("prio_after_windex", 32'(arr_windex), 32'd3);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    do_read(3'd3, 1'b1);

    // Reset in the middle of a sweep, at the cycle addressing entry 3
    write_all(1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("abort%0d_windex", k), 32'(arr_windex), 32'(k));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("abort_rst_noload", 32'(arr_load), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy_clear", 32'(flush_busy), 32'd0);
    chk("abort_noload", 32'(arr_load), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("abort_noload_later", 32'(arr_load), 32'd0);
    for (int i = 0; i < N; i++) do_read(S'(i), (i < 3) ? 1'b0 : 1'b1);
`else
    // Without the flush feature, flush_req has no effect
    write_all(1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    chk("noflush_noload", 32'(arr_load), 32'd0);
    chk("noflush_busy", 32'(flush_busy), 32'd0);
    chk("noflush_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    flush_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("noflush%0d_noload", c), 32'(arr_load), 32'd0);
      chk($sformatf("noflush%0d_busy", c), 32'(flush_busy), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) do_read(S'(i), 1'b1);
    @(negedge clk);
    flush_req = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_index = 3'd4; req_wdata = 1'b0;
    #1;
    chk("noflush_write_ready", 32'(req_ready), 32'd1);
    chk("noflush_write_load", 32'(arr_load), 32'd1);
    @(negedge clk);
    flush_req = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    do_read(3'd4, 1'b0);
    do_read(3'd3, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/array_req_ctrl.md
ARRAY_REQ_CTRL -- requirements
Module: array_req_ctrl

Interface
REQ-001 SHALL have parameter: s_index, 3, index width; num_sets = 2**s_index.
REQ-002 SHALL have parameter: width, 1, data width.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  1  client request present.
REQ-006 SHALL have port: req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: req_index  input  s_index  target entry.
REQ-009 SHALL have port: req_wdata  input  width  write data.
REQ-010 SHALL have port: resp_valid  output  1  read data available.
REQ-011 SHALL have port: resp_ready  input  1  client consumes response.
REQ-012 SHALL have port: resp_rdata  output  width  read data.
REQ-013 SHALL have port: flush_req  input  1  request zeroing of all entries.
REQ-014 SHALL have port: flush_busy  output  1  flush sweep in progress.
REQ-015 SHALL have ports to the storage array: arr_read, arr_load (output 1), arr_rindex, arr_windex (output s_index), arr_datain (output width), arr_dataout (input width); the array has 1-cycle registered read.

Function
REQ-016 SHALL implement states IDLE and FLUSH.
REQ-017 SHALL drive req_ready = (state==IDLE) && !flush_req && (!resp_valid || resp_ready).
REQ-018 SHALL, on accepted read, assert arr_read=1, arr_rindex=req_index combinationally in the accept cycle N.
REQ-019 SHALL assert resp_valid from cycle N+1 until the cycle resp_ready is high, resp_rdata = arr_dataout throughout.
REQ-020 SHALL NOT assert arr_read while a response is pending and unconsumed, so arr_dataout holds the result.
REQ-021 SHALL, on accepted write, assert arr_load=1, arr_windex=req_index, arr_datain=req_wdata in the accept cycle; writes produce no response.
REQ-022 SHALL allow back-to-back reads: response consumed in cycle M and new read accepted in cycle M yields resp_valid continuously with new data at M+1.
REQ-023 SHALL accept flush_req only in IDLE with no pending response; flush_req wins over req_valid in the same cycle (req_ready low).
REQ-024 SHALL in FLUSH write '0 to index cnt=0..num_sets-1, one per cycle (arr_load=1, arr_windex=cnt), taking exactly num_sets cycles, then return to IDLE.
REQ-025 SHALL hold flush_busy=1 exactly while in FLUSH; req_ready=0 during FLUSH.
REQ-026 SHALL wrap cnt from num_sets-1 to 0 on FLUSH exit (no overflow bit needed).
REQ-027 SHALL keep arr_read, arr_load low in any cycle without an accepted request or flush write.

Reset
REQ-028 SHALL on rst: state=IDLE, cnt=0, resp_valid=0, flush_busy=0; req_ready reverts to 1 the cycle after.
REQ-029 SHALL abort flush or pending response on rst mid-operation, discarding it without further array writes.

Configuration
REQ-030 SHALL compile flush logic only when ARRAY_REQ_CTRL_FLUSH_EN is defined; without it flush_req is ignored, flush_busy tied 0, FLUSH state absent, req_ready omits the flush_req term.

Structure
REQ-031 SHALL place the state enum (IDLE, FLUSH) in package array_req_pkg.
REQ-032 SHALL be a single module with no sub-module; verification bench instantiates it with array_2 as the storage.

Verification
REQ-033 Write idx 5 = 1, then read idx 5 -> resp_valid next cycle, resp_rdata=1.
REQ-034 Read idx 2 with resp_ready=0 for 3 cycles -> resp_valid held, req_ready=0, rdata stable; resp_ready=1 -> consumed.
REQ-035 Write all 8 entries =1, assert flush_req -> flush_busy 8 cycles, windex 0..7, then all reads return 0.
REQ-036 flush_req and req_valid same IDLE cycle -> flush starts, request not accepted until flush_busy drops.
REQ-037 rst at flush cycle 3 -> next cycle IDLE, flush_busy=0, no further arr_load, entries 3..7 unchanged.
REQ-038 Build without ARRAY_REQ_CTRL_FLUSH_EN, pulse flush_req -> no arr_load, flush_busy=0, reads unaffected.
